// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin message arbiter feeding one UART transmit FIFO, with mid-message idle timeout
module uart_tx_arbiter #(
  parameter int DATA_BITS      = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_full,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic                          wr_en,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          abort,
  output logic [$clog2(NUM_REQ)-1:0]    abort_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] gidx, last_ptr, nidx;
  logic [CW-1:0] tcnt;
  logic started, xfer;
  int c;
  // descending scan so the candidate closest after last_ptr is written last and wins
  always_comb begin
    nidx = '0;
    c = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      c = (int'(last_ptr) + 1 + k) % NUM_REQ;
      if (req_valid[c[IW-1:0]]) nidx = c[IW-1:0];
    end
  end
  assign busy      = state == GRANT;
  assign xfer      = busy & req_valid[gidx] & ~tx_full;
  assign wr_en     = xfer;
  assign req_ready = (busy & ~tx_full) ? grant : '0;
  assign tx_data   = busy ? req_data[int'(gidx)*DATA_BITS +: DATA_BITS] : '0;
  // started keeps the first edge after reset release free of arbitration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      last_ptr <= IW'(NUM_REQ-1);
      tcnt     <= '0;
      abort    <= 1'b0;
      abort_id <= '0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      abort   <= 1'b0;
      if (state == IDLE) begin
        if (started && |req_valid) begin
          state <= GRANT;
          gidx  <= nidx;
          grant <= NUM_REQ'(1) << nidx;
          tcnt  <= '0;
        end
      end else if (xfer) begin
        tcnt <= '0;
        if (req_last[gidx]) begin
          state    <= IDLE;
          grant    <= '0;
          last_ptr <= gidx;
        end
      end else if (!req_valid[gidx]) begin
        if (tcnt == CW'(TIMEOUT_CYCLES-1)) begin
          state    <= IDLE;
          grant    <= '0;
          last_ptr <= gidx;
          abort    <= 1'b1;
          abort_id <= gidx;
        end else begin
          tcnt <= tcnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter (4 requesters, 16-cycle timeout)
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic tx_full, wr_en, busy, abort;
  logic [DW-1:0] tx_data;
  logic [1:0] abort_id;
  logic [N-1:0] hold;
  logic [10:0] src[$];
  logic [9:0] sb[$];
  int nchk = 0, nfail = 0, n_abort = 0;
  int n, a0;

  uart_tx_arbiter #(.DATA_BITS(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full), .tx_data(tx_data),
    .wr_en(wr_en), .grant(grant), .busy(busy), .abort(abort), .abort_id(abort_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int id, input bit last, input logic [7:0] d);
    src.push_back({2'(id), last, d});
    sb.push_back({2'(id), d});
  endtask

  task automatic drive();
    logic [N-1:0] f;
    f = '0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < src.size(); k++)
        if (!f[i] && src[k][10:9] == 2'(i)) begin
          f[i] = 1'b1;
          if (!hold[i]) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = src[k][7:0];
            req_last[i] = src[k][8];
          end
        end
  endtask

  task automatic tick();
    int xg;
    logic [1:0] gid;
    logic [9:0] exp;
    bit done;
    xg = -1;
    gid = '0;
    @(negedge clk);
    if (abort) n_abort++;
    nchk++;
    assert ($onehot0(grant)) else begin
      nfail++;
      $error("FAIL grant_onehot: observed %b expected one-hot or zero", grant);
    end
    if (wr_en) begin
      for (int i = 0; i < N; i++) if (grant[i]) gid = 2'(i);
      nchk++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("FAIL unexpected_write: observed id %0d data %h expected no write", gid, tx_data);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        nchk++;
        assert ({gid, tx_data} === exp) else begin
          nfail++;
          $error("FAIL write: observed id %0d data %h expected id %0d data %h", gid, tx_data, exp[9:8], exp[7:0]);
        end
      end
      xg = int'(gid);
    end
    @(posedge clk);
    #1;
    done = 1'b0;
    if (xg >= 0)
      for (int k = 0; k < src.size(); k++)
        if (!done && src[k][10:9] == 2'(xg)) begin
          src.delete(k);
          done = 1'b1;
        end
    drive();
  endtask

  initial begin
    reset_n = 1'b0;
    tx_full = 1'b0;
    hold = '0;
    drive();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    chk("rst_abort_id", abort_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_tx_data", tx_data, 0);
    // single requester message
    put(1, 0, 8'h41); put(1, 0, 8'h42); put(1, 1, 8'h43);
    drive();
    @(posedge clk);
    #1;
    chk("rst_hold_grant", grant, 0);
    reset_n = 1'b1;
    tick();
    chk("first_edge_idle", busy, 0);
    tick();
    chk("single_grant", grant, 4'b0010);
    repeat (3) tick();
    chk("single_drained", sb.size(), 0);
    chk("single_idle", busy, 0);
    // round robin from reset: order 0,1,2,3,0
    reset_n = 1'b0;
    #1;
    for (int r = 0; r < N; r++) begin
      put(r, 0, 8'(r*16+1));
      put(r, 1, 8'(r*16+2));
    end
    put(0, 0, 8'h81); put(0, 1, 8'h82);
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin tick(); n++; end
    chk("rr_cycles", n, 16);
    tick();
    chk("rr_idle", busy, 0);
    // backpressure stall mid-message
    a0 = n_abort;
    put(1, 0, 8'h61); put(1, 0, 8'h62); put(1, 1, 8'h63);
    drive();
    tick();
    chk("bp_grant", grant, 4'b0010);
    tick();
    tx_full = 1'b1;
    #1;
    chk("bp_ready", req_ready, 0);
    repeat (50) begin
      tick();
      chk("bp_no_write", wr_en, 0);
    end
    chk("bp_busy", busy, 1);
    tx_full = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 10) begin tick(); n++; end
    chk("bp_resume_cycles", n, 2);
    chk("bp_idle", busy, 0);
    chk("bp_no_abort", n_abort, a0);
    // timeout: one non-last character then silence
    put(2, 0, 8'h55);
    drive();
    tick();
    chk("to_grant", grant, 4'b0100);
    tick();
    a0 = n_abort;
    n = 0;
    while (n_abort == a0 && n < 40) begin tick(); n++; end
    chk("to_latency", n, 17);
    chk("to_pulse_end", abort, 0);
    chk("to_abort_id", abort_id, 2);
    chk("to_idle", busy, 0);
    put(3, 1, 8'h73); put(1, 1, 8'h71);
    drive();
    n = 0;
    while (sb.size() > 0 && n < 20) begin tick(); n++; end
    chk("to_next_search", sb.size(), 0);
    // last transfer on the timeout cycle
    a0 = n_abort;
    put(0, 0, 8'h10); put(0, 1, 8'h11);
    drive();
    tick();
    chk("sim_grant", grant, 4'b0001);
    tick();
    hold[0] = 1'b1;
    drive();
    repeat (15) tick();
    chk("sim_still_busy", busy, 1);
    hold[0] = 1'b0;
    drive();
    #1;
    chk("sim_wr_en", wr_en, 1);
    tick();
    chk("sim_abort", abort, 0);
    chk("sim_idle", busy, 0);
    chk("sim_abort_count", n_abort, a0);
    // reset during the second character
    a0 = n_abort;
    put(0, 0, 8'h21); put(0, 0, 8'h22); put(0, 1, 8'h23);
    drive();
    tick();
    chk("mr_grant", grant, 4'b0001);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_grant_rst", grant, 0);
    chk("mr_busy_rst", busy, 0);
    chk("mr_ready_rst", req_ready, 0);
    chk("mr_wr_en_rst", wr_en, 0);
    chk("mr_tx_data_rst", tx_data, 0);
    chk("mr_abort_rst", abort, 0);
    chk("mr_abort_id_rst", abort_id, 0);
    put(1, 1, 8'h31);
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("mr_first_edge", busy, 0);
    tick();
    chk("mr_regrant", grant, 4'b0001);
    n = 0;
    while (sb.size() > 0 && n < 20) begin tick(); n++; end
    chk("mr_drained", sb.size(), 0);
    chk("mr_no_abort", n_abort, a0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, the width of one character.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (2..16).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the mid-message idle limit in clk cycles (>=2).
REQ-004 Port clk  input  1  is the system clock; all state SHALL change only on its rising edge, except under reset.
REQ-005 Port reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Port req_valid  input  NUM_REQ  is the per-requester "character available" flag.
REQ-007 Port req_data  input  NUM_REQ*DATA_BITS  carries the characters; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-008 Port req_last  input  NUM_REQ  marks the final character of a message, per requester.
REQ-009 Port req_ready  output  NUM_REQ  is the per-requester acceptance flag.
REQ-010 Port tx_full  input  1  is the UART transmit FIFO full flag.
REQ-011 Port tx_data  output  DATA_BITS  is the character presented to the UART transmit FIFO.
REQ-012 Port wr_en  output  1  is the UART transmit FIFO write strobe.
REQ-013 Port grant  output  NUM_REQ  is the one-hot owner of the UART; all zero when idle.
REQ-014 Port busy  output  1  is high while a message is granted.
REQ-015 Port abort  output  1  is a one-cycle pulse on a timeout release.
REQ-016 Port abort_id  output  clog2(NUM_REQ)  is the index of the aborted requester; it holds its value until the next abort.

Function
REQ-017 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-018 IDLE: if any req_valid bit is high, the block SHALL register grant to the first set requester, searching from (last_ptr+1) mod NUM_REQ upward with wrap, and enter GRANT on the next cycle.
REQ-019 IDLE SHALL drive grant=0, req_ready=0 and wr_en=0, giving exactly one arbitration bubble cycle per message.
REQ-020 GRANT: req_ready[g] SHALL equal ~tx_full, combinationally; all other req_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when req_valid[g] & req_ready[g]; wr_en SHALL equal the transfer condition and tx_data SHALL equal the slice for requester g (zero added latency).
REQ-022 When tx_data is not being written, it SHALL still show the granted slice in GRANT and zero in IDLE.
REQ-023 A transfer with req_last[g]=1 SHALL return the FSM to IDLE and set last_ptr=g on the next cycle.
REQ-024 Ownership SHALL be held for the whole message; other requesters' valid signals SHALL NOT change grant in GRANT.
REQ-025 Timeout counter: cleared on entry to GRANT and on every transfer; it SHALL increment each GRANT cycle with req_valid[g]=0.
REQ-026 Timeout counter: it SHALL hold, not increment, while req_valid[g]=1 and tx_full=1, because a backpressure stall is not a timeout.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1 and increments, the block SHALL return to IDLE, pulse abort for one cycle, load abort_id=g, and set last_ptr=g.
REQ-028 If a last transfer and the timeout condition occur in the same cycle, the transfer SHALL take priority and no abort SHALL be raised.
REQ-029 busy SHALL equal (state==GRANT).
REQ-030 grant SHALL always be one-hot or zero.
REQ-031 In steady contention, requester i SHALL wait at most NUM_REQ-1 messages before being granted.

Reset
REQ-032 While reset_n=0, the block SHALL force state=IDLE, last_ptr=NUM_REQ-1 (so requester 0 is searched first), timeout counter=0, grant=0, busy=0, abort=0 and abort_id=0.
REQ-033 While reset_n=0, the block SHALL also force req_ready=0, wr_en=0 and tx_data=0.
REQ-034 Reset asserted mid-message SHALL drop the grant immediately, with no abort pulse; the partial message is the system's responsibility.
REQ-035 After reset_n rises, the first grant SHALL occur no earlier than the second clk edge.

Verification
REQ-036 Single requester: req 1 sends 3 characters 0x41,0x42,0x43 (last on 0x43) with tx_full=0 -> grant=0010 on cycle 2, three consecutive wr_en cycles carrying 0x41,0x42,0x43, then IDLE.
REQ-037 Round robin: all 4 requesters continuously send 2-character messages -> grant order 0,1,2,3,0, with one bubble cycle between messages.
REQ-038 Backpressure: tx_full=1 for 50 cycles mid-message while valid is held -> no wr_en, no abort, and the message completes after tx_full drops.
REQ-039 Timeout: with TIMEOUT_CYCLES=16, req 2 sends one non-last character then drops valid -> abort pulses exactly 16 cycles later, abort_id=2, and the next grant search starts at req 3.
REQ-040 Reset mid-message: reset_n pulsed low during the second character of req 0 -> all outputs are 0 asynchronously, and after release req 0 is granted first again.
REQ-041 Simultaneous events: a last transfer lands on the timeout cycle -> wr_en=1, abort=0, FSM returns to IDLE.
